// File: rtl/spi_pwm_pkg.sv
// Shared constants for the SPI register block and the PWM peripheral.
// Register map, duty encoding and default timebase settings.
package spi_pwm_pkg;

  localparam logic [2:0] ADDR_EN_OUT_LO = 3'd0;
  localparam logic [2:0] ADDR_EN_OUT_HI = 3'd1;
  localparam logic [2:0] ADDR_EN_PWM_LO = 3'd2;
  localparam logic [2:0] ADDR_EN_PWM_HI = 3'd3;
  localparam logic [2:0] ADDR_DUTY      = 3'd4;

  localparam logic [7:0] DUTY_FULL = 8'hFF;

  localparam int DEFAULT_PRESCALE   = 13;
  localparam int DEFAULT_PERIOD_MAX = 254;

  // Full-scale duty must stay high even on the last counter value.
  function automatic logic pwm_level(input logic [7:0] count, input logic [7:0] duty);
    return (duty == DUTY_FULL) || (count < duty);
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// PWM timebase: prescaler producing a step strobe, plus the 8-bit period counter.
// period_start is a registered pulse coinciding with the first cycle of counter 0.
module pwm_timebase
  import spi_pwm_pkg::*;
#(
  parameter int PRESCALE   = DEFAULT_PRESCALE,
  parameter int PERIOD_MAX = DEFAULT_PERIOD_MAX
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] count,
  output logic       step,
  output logic       period_start
);

  localparam int              PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [7:0]      CNT_LAST   = 8'(PERIOD_MAX);

  logic [PW-1:0] presc;

  assign step = (presc == PRESC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc        <= '0;
      count        <= 8'h00;
      period_start <= 1'b0;
    end else begin
      presc        <= step ? '0 : presc + 1'b1;
      period_start <= step && (count == CNT_LAST);
      if (step) begin
        count <= (count == CNT_LAST) ? 8'h00 : count + 8'd1;
      end
    end
  end

endmodule

// File: rtl/pwm_peripheral.sv
// 16-output PWM peripheral: per-pin off / static high / shared PWM, registered outputs.
// Define PWM_SHADOW_EN to latch the duty only at period boundaries (glitch-free duty updates).
module pwm_peripheral
  import spi_pwm_pkg::*;
#(
  parameter int PRESCALE   = DEFAULT_PRESCALE,
  parameter int PERIOD_MAX = DEFAULT_PERIOD_MAX
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        pwm_period_start
);

  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [15:0] out_next;
  logic [7:0]  count;
  logic [7:0]  duty_act;
  logic        step;
  logic        pwm;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  pwm_timebase #(
    .PRESCALE   (PRESCALE),
    .PERIOD_MAX (PERIOD_MAX)
  ) u_timebase (
    .clk          (clk),
    .rst_n        (rst_n),
    .count        (count),
    .step         (step),
    .period_start (pwm_period_start)
  );

`ifdef PWM_SHADOW_EN
  localparam logic [7:0] CNT_LAST = 8'(PERIOD_MAX);

  logic first_step;
  logic wrap;

  assign wrap = step && (count == CNT_LAST);

  // Load on the wrap into counter 0, and once on the first strobe after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_act   <= 8'h00;
      first_step <= 1'b1;
    end else if (step) begin
      first_step <= 1'b0;
      if (wrap || first_step) begin
        duty_act <= pwm_duty_cycle;
      end
    end
  end
`else
  logic unused_step;

  assign unused_step = step;
  assign duty_act    = pwm_duty_cycle;
`endif

  assign pwm = pwm_level(count, duty_act);

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_mux
      assign out_next[gi] = en_out[gi] & (~en_pwm[gi] | pwm);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= 16'h0000;
    end else begin
      out <= out_next;
    end
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Bench for pwm_peripheral: cycle scoreboard plus per-scenario duty/period measurements.
// Honours PWM_SHADOW_EN the same way as the design.
module tb_pwm_peripheral;

  localparam int P  = 2;
  localparam int PM = 254;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [7:0]  duty;
  logic [15:0] out;
  logic        ps;
  logic [15:0] out1;
  logic        ps1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pwm_peripheral #(.PRESCALE(P), .PERIOD_MAX(PM)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .en_reg_out_7_0   (en_out[7:0]),
    .en_reg_out_15_8  (en_out[15:8]),
    .en_reg_pwm_7_0   (en_pwm[7:0]),
    .en_reg_pwm_15_8  (en_pwm[15:8]),
    .pwm_duty_cycle   (duty),
    .out              (out),
    .pwm_period_start (ps)
  );

  pwm_peripheral #(.PRESCALE(1), .PERIOD_MAX(PM)) dut1 (
    .clk              (clk),
    .rst_n            (rst_n),
    .en_reg_out_7_0   (en_out[7:0]),
    .en_reg_out_15_8  (en_out[15:8]),
    .en_reg_pwm_7_0   (en_pwm[7:0]),
    .en_reg_pwm_15_8  (en_pwm[15:8]),
    .pwm_duty_cycle   (duty),
    .out              (out1),
    .pwm_period_start (ps1)
  );

  // Reference model of the PRESCALE=2 instance; each posedge pushes the value out must take.
  logic [7:0] m_presc;
  logic [7:0] m_cnt;
  logic [7:0] m_duty;
  logic       m_first;
  wire        m_step = (m_presc == 8'(P - 1));
  wire        m_wrap = m_step && (m_cnt == 8'(PM));
`ifdef PWM_SHADOW_EN
  wire [7:0]  m_duty_act = m_duty;
`else
  wire [7:0]  m_duty_act = duty;
`endif
  wire        m_pwm = (m_duty_act == 8'hFF) || (m_cnt < m_duty_act);
  wire [15:0] m_exp = en_out & (~en_pwm | {16{m_pwm}});

  typedef struct packed {
    logic [15:0] o;
    logic        p;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_presc <= 8'd0;
      m_cnt   <= 8'd0;
      m_duty  <= 8'd0;
      m_first <= 1'b1;
      sb.delete();
    end else begin
      sb.push_back({m_exp, m_wrap});
      m_presc <= m_step ? 8'd0 : m_presc + 8'd1;
      if (m_step) begin
        m_cnt   <= m_wrap ? 8'd0 : m_cnt + 8'd1;
        m_first <= 1'b0;
        if (m_wrap || m_first) m_duty <= duty;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      total++;
      if (out !== 16'h0000 || ps !== 1'b0) begin
        bad++;
        $display("FAIL sb_reset t=%0t out=%h ps=%b required out=0000 ps=0", $time, out, ps);
      end
    end else if (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (out !== e.o || ps !== e.p) begin
        bad++;
        $display("FAIL sb_cycle t=%0t out=%h ps=%b required out=%h ps=%b", $time, out, ps, e.o, e.p);
      end
    end
  end

  task automatic wait_ps(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (ps === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0; en_out = 16'h0000; en_pwm = 16'h0000; duty = 8'h00;
    repeat (3) @(negedge clk);
    total++;
    if (out !== 16'h0000 || ps !== 1'b0) begin
      bad++; $display("FAIL reset_hold out=%h ps=%b required 0000/0", out, ps);
    end
    rst_n = 1'b1; en_out = 16'hFFFF;
    repeat (100) @(negedge clk);
    total++;
    if (out !== 16'hFFFF) begin
      bad++; $display("FAIL pre_reset out=%h required ffff", out);
    end
    @(posedge clk); #3 rst_n = 1'b0; #1;
    total++;
    if (out !== 16'h0000 || ps !== 1'b0) begin
      bad++; $display("FAIL reset_async out=%h ps=%b required 0000/0", out, ps);
    end
    @(negedge clk); rst_n = 1'b1; en_out = 16'h0000;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (ps !== 1'b1 && n < 600);
    total++;
    if (n != 510) begin
      bad++; $display("FAIL first_period_start clk=%0d required 510", n);
    end
    $display("reset: first period_start after %0d clk", n);
  endtask

  task automatic test_static();
    int changes = 0;
    en_out = 16'hA5A5; en_pwm = 16'h0000;
    @(negedge clk);
    total++;
    if (out !== 16'hA5A5) begin
      bad++; $display("FAIL static_latency out=%h required a5a5", out);
    end
    for (int i = 0; i < 3 * 510; i++) begin
      @(negedge clk);
      if (out !== 16'hA5A5) changes++;
    end
    total++;
    if (changes != 0) begin
      bad++; $display("FAIL static_hold deviating_cycles=%0d required 0", changes);
    end
    $display("static: out=%h deviations=%0d", out, changes);
  endtask

  task automatic test_duty_level(input logic [7:0] d, input int exp_high);
    bit ok;
    int hi = 0;
    int other = 0;
    en_out = 16'h0001; en_pwm = 16'h0001; duty = d;
    wait_ps(ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL duty_wait_ps duty=%h got timeout required pulse", d);
    end
    @(negedge clk);
    for (int i = 0; i < 510; i++) begin
      @(negedge clk);
      if (out[0] === 1'b1) hi++;
      if (out[15:1] !== 15'h0) other++;
    end
    total++;
    if (hi != exp_high) begin
      bad++; $display("FAIL duty_high duty=%h high=%0d required %0d", d, hi, exp_high);
    end
    total++;
    if (other != 0) begin
      bad++; $display("FAIL duty_unused_bits duty=%h nonzero_cycles=%0d required 0", d, other);
    end
    $display("duty %h: high %0d of 510 clk", d, hi);
  endtask

  task automatic test_mixed();
    bit ok;
    int hi = 0;
    int hi_bad = 0;
    int align_bad = 0;
    en_out = 16'hFFFF; en_pwm = 16'h00FF; duty = 8'h40;
    wait_ps(ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL mixed_wait_ps got timeout required pulse");
    end
    @(negedge clk);
    for (int i = 0; i < 510; i++) begin
      @(negedge clk);
      if (out[0] === 1'b1) hi++;
      if (out[15:8] !== 8'hFF) hi_bad++;
      if (out[7:0] !== 8'h00 && out[7:0] !== 8'hFF) align_bad++;
    end
    total++;
    if (hi != 128) begin
      bad++; $display("FAIL mixed_high high=%0d required 128", hi);
    end
    total++;
    if (hi_bad != 0) begin
      bad++; $display("FAIL mixed_static bad_cycles=%0d required 0", hi_bad);
    end
    total++;
    if (align_bad != 0) begin
      bad++; $display("FAIL mixed_phase bad_cycles=%0d required 0", align_bad);
    end
    $display("mixed: low byte high %0d of 510 clk", hi);
  endtask

  task automatic test_duty_change();
    bit ok;
    bit changed = 1'b0;
    bit pending = 1'b0;
    int hi = 0;
    en_out = 16'h0001; en_pwm = 16'h0001; duty = 8'h80;
    wait_ps(ok);
    wait_ps(ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL change_wait_ps got timeout required pulse");
    end
    @(negedge clk);
    for (int i = 0; i < 510; i++) begin
      @(negedge clk);
      if (out[0] === 1'b1) hi++;
      if (pending) begin
        pending = 1'b0;
        total++;
`ifdef PWM_SHADOW_EN
        if (out[0] !== 1'b1) begin
          bad++; $display("FAIL change_hold out0=%b required 1", out[0]);
        end
`else
        if (out[0] !== 1'b0) begin
          bad++; $display("FAIL change_fall out0=%b required 0", out[0]);
        end
`endif
      end
      if (!changed && m_cnt == 8'h20) begin
        duty = 8'h10; changed = 1'b1; pending = 1'b1;
      end
    end
    total++;
    if (!changed) begin
      bad++; $display("FAIL change_point reached=0 required 1");
    end
`ifdef PWM_SHADOW_EN
    total++;
    if (hi != 256) begin
      bad++; $display("FAIL change_current_pulse high=%0d required 256", hi);
    end
`endif
    $display("duty change: period with change high %0d clk", hi);
    wait_ps(ok);
    @(negedge clk);
    hi = 0;
    for (int i = 0; i < 510; i++) begin
      @(negedge clk);
      if (out[0] === 1'b1) hi++;
    end
    total++;
    if (hi != 32) begin
      bad++; $display("FAIL change_next_pulse high=%0d required 32", hi);
    end
    $display("duty change: next period high %0d clk", hi);
  endtask

  task automatic test_prescale1();
    int n;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (ps1 !== 1'b1 && n < 600);
    total++;
    if (ps1 !== 1'b1) begin
      bad++; $display("FAIL p1_wait_ps got timeout required pulse");
    end
    for (int r = 0; r < 2; r++) begin
      n = 0;
      do begin
        @(negedge clk); n++;
      end while (ps1 !== 1'b1 && n < 600);
      total++;
      if (n != 255) begin
        bad++; $display("FAIL p1_period clk=%0d required 255", n);
      end
      $display("prescale1: period %0d clk", n);
    end
  endtask

  initial begin
    test_reset();
    test_static();
    test_duty_level(8'h00, 0);
    test_duty_level(8'hFF, 510);
    test_duty_level(8'h80, 256);
    test_mixed();
    test_duty_change();
    test_prescale1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
